// File: rtl/ptw_pte_fetch_master.sv
// Single-outstanding AXI4 read master returning 64-bit PTEs to a TLB walker.
// Optional single-entry last-PTE cache enabled by defining PTW_LAST_PTE_CACHE_EN.
module ptw_pte_fetch_master #(
   parameter int unsigned          ADDR_WIDTH = 64,
   parameter int unsigned          DATA_WIDTH = 64,
   parameter int unsigned          ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0]  AXI_ID     = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ADDR_IN_VALID,
   input  logic [ADDR_WIDTH-1:0] ADDR_IN,
   output logic                  DATA_OUT_VALID,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  ACCESS_ERR,
   output logic                  BUSY,
   output logic                  REQ_OVERRUN,
   input  logic                  TLB_FLUSH,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_ARADDR,
   output logic [ID_WIDTH-1:0]   M_ARID,
   output logic [7:0]            M_ARLEN,
   output logic [2:0]            M_ARSIZE,
   output logic [1:0]            M_ARBURST,
   input  logic                  M_RVALID,
   output logic                  M_RREADY,
   input  logic [DATA_WIDTH-1:0] M_RDATA,
   input  logic [1:0]            M_RRESP,
   input  logic                  M_RLAST
);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

   state_t                state, state_nxt;
   logic                  arvalid_nxt, rready_nxt, dov_nxt, err_nxt, busy_nxt, overrun_nxt;
   logic [ADDR_WIDTH-1:0] araddr_nxt, req_addr;
   logic [DATA_WIDTH-1:0] data_nxt, cache_pte;
   logic                  cache_hit;

   assign M_ARID    = AXI_ID;
   assign M_ARLEN   = 8'd0;
   assign M_ARSIZE  = 3'b011;
   assign M_ARBURST = 2'b01;

   // PTEs are 8-byte aligned
   assign req_addr = ADDR_IN & ~ADDR_WIDTH'(7);

`ifdef PTW_LAST_PTE_CACHE_EN
   logic                  cache_vld, cache_fill;
   logic [ADDR_WIDTH-1:0] cache_addr;

   assign cache_hit  = cache_vld && !TLB_FLUSH && (req_addr == cache_addr);
   assign cache_fill = (state == S_R) && M_RVALID && (M_RRESP == 2'b00) && M_RLAST;

   // Flush wins over a coincident fill so a possibly stale PTE is never kept
   always_ff @(posedge CLK) begin
      if (RST) begin
         cache_vld  <= 1'b0;
         cache_addr <= '0;
         cache_pte  <= '0;
      end else if (TLB_FLUSH) begin
         cache_vld  <= 1'b0;
      end else if (cache_fill) begin
         cache_vld  <= 1'b1;
         cache_addr <= M_ARADDR;
         cache_pte  <= M_RDATA;
      end
   end
`else
   logic unused_flush;

   assign unused_flush = TLB_FLUSH;
   assign cache_hit    = 1'b0;
   assign cache_pte    = '0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      arvalid_nxt = M_ARVALID;
      araddr_nxt  = M_ARADDR;
      rready_nxt  = M_RREADY;
      dov_nxt     = 1'b0;
      err_nxt     = 1'b0;
      data_nxt    = DATA_OUT;
      overrun_nxt = REQ_OVERRUN | (ADDR_IN_VALID && (state != S_IDLE));

      case (state)
         S_IDLE: begin
            if (ADDR_IN_VALID) begin
               if (cache_hit) begin
                  state_nxt = S_RESP;
                  dov_nxt   = 1'b1;
                  data_nxt  = cache_pte;
               end else begin
                  state_nxt   = S_AR;
                  arvalid_nxt = 1'b1;
                  araddr_nxt  = req_addr;
               end
            end
         end
         S_AR: begin
            if (M_ARREADY) begin
               state_nxt   = S_R;
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
            end
         end
         S_R: begin
            if (M_RVALID) begin
               state_nxt  = S_RESP;
               rready_nxt = 1'b0;
               dov_nxt    = 1'b1;
               // Errored beats return an invalid PTE so the walker faults
               data_nxt   = (M_RRESP == 2'b00) ? M_RDATA : '0;
               err_nxt    = (M_RRESP != 2'b00) || !M_RLAST;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= S_IDLE;
         M_ARVALID      <= 1'b0;
         M_ARADDR       <= '0;
         M_RREADY       <= 1'b0;
         DATA_OUT_VALID <= 1'b0;
         DATA_OUT       <= '0;
         ACCESS_ERR     <= 1'b0;
         BUSY           <= 1'b0;
         REQ_OVERRUN    <= 1'b0;
      end else begin
         state          <= state_nxt;
         M_ARVALID      <= arvalid_nxt;
         M_ARADDR       <= araddr_nxt;
         M_RREADY       <= rready_nxt;
         DATA_OUT_VALID <= dov_nxt;
         DATA_OUT       <= data_nxt;
         ACCESS_ERR     <= err_nxt;
         BUSY           <= busy_nxt;
         REQ_OVERRUN    <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_ptw_pte_fetch_master.sv
// Directed bench for ptw_pte_fetch_master; cache cases run when PTW_LAST_PTE_CACHE_EN is defined.
module tb_ptw_pte_fetch_master;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 4;

   logic          CLK;
   logic          RST;
   logic          ADDR_IN_VALID;
   logic [AW-1:0] ADDR_IN;
   logic          DATA_OUT_VALID;
   logic [DW-1:0] DATA_OUT;
   logic          ACCESS_ERR;
   logic          BUSY;
   logic          REQ_OVERRUN;
   logic          TLB_FLUSH;
   logic          M_ARVALID;
   logic          M_ARREADY;
   logic [AW-1:0] M_ARADDR;
   logic [IW-1:0] M_ARID;
   logic [7:0]    M_ARLEN;
   logic [2:0]    M_ARSIZE;
   logic [1:0]    M_ARBURST;
   logic          M_RVALID;
   logic          M_RREADY;
   logic [DW-1:0] M_RDATA;
   logic [1:0]    M_RRESP;
   logic          M_RLAST;

   int n_chk  = 0;
   int n_pass = 0;

   ptw_pte_fetch_master dut (
      .CLK(CLK), .RST(RST),
      .ADDR_IN_VALID(ADDR_IN_VALID), .ADDR_IN(ADDR_IN),
      .DATA_OUT_VALID(DATA_OUT_VALID), .DATA_OUT(DATA_OUT),
      .ACCESS_ERR(ACCESS_ERR), .BUSY(BUSY), .REQ_OVERRUN(REQ_OVERRUN),
      .TLB_FLUSH(TLB_FLUSH),
      .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
      .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
      .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one cycle; outputs are then sampled 1ns after the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".dov"},     64'(DATA_OUT_VALID), 64'd0);
      chk({tag, ".data"},    DATA_OUT,            64'd0);
      chk({tag, ".err"},     64'(ACCESS_ERR),     64'd0);
      chk({tag, ".busy"},    64'(BUSY),           64'd0);
      chk({tag, ".overrun"}, 64'(REQ_OVERRUN),    64'd0);
      chk({tag, ".arvalid"}, 64'(M_ARVALID),      64'd0);
      chk({tag, ".araddr"},  M_ARADDR,            64'd0);
      chk({tag, ".rready"},  64'(M_RREADY),       64'd0);
   endtask

   // One full AXI fetch with optional AR/R stalls and an overrun pulse in R
   task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [63:0] exp_araddr,
                           input int ar_dly, input int r_dly,
                           input logic [63:0] rdata, input logic [1:0] rresp, input logic rlast,
                           input logic [63:0] exp_data, input logic exp_err, input bit ovr);
      ADDR_IN_VALID = 1'b1;
      ADDR_IN       = addr;
      tick();
      ADDR_IN_VALID = 1'b0;
      chk({tag, ".busy_rise"}, 64'(BUSY),      64'd1);
      chk({tag, ".arvalid"},   64'(M_ARVALID), 64'd1);
      chk({tag, ".araddr"},    M_ARADDR,       exp_araddr);
      for (int i = 0; i < ar_dly; i++) begin
         M_ARREADY = 1'b0;
         M_RVALID  = 1'b1;             // stray beat must be ignored while RREADY is low
         M_RDATA   = 64'hBAD0_BAD0_BAD0_BAD0;
         tick();
         chk({tag, ".ar_hold_valid"}, 64'(M_ARVALID),      64'd1);
         chk({tag, ".ar_hold_addr"},  M_ARADDR,            exp_araddr);
         chk({tag, ".ar_no_dov"},     64'(DATA_OUT_VALID), 64'd0);
      end
      M_RVALID  = 1'b0;
      M_ARREADY = 1'b1;
      tick();
      M_ARREADY = 1'b0;
      chk({tag, ".ar_drop"}, 64'(M_ARVALID), 64'd0);
      chk({tag, ".rready"},  64'(M_RREADY),  64'd1);
      for (int i = 0; i < r_dly; i++) begin
         if (ovr && i == 0) begin
            ADDR_IN_VALID = 1'b1;
            ADDR_IN       = addr ^ 64'h100;
         end
         tick();
         ADDR_IN_VALID = 1'b0;
         chk({tag, ".r_hold"},   64'(M_RREADY),       64'd1);
         chk({tag, ".r_no_ar"},  64'(M_ARVALID),      64'd0);
         chk({tag, ".r_no_dov"}, 64'(DATA_OUT_VALID), 64'd0);
         if (ovr) chk({tag, ".overrun_set"}, 64'(REQ_OVERRUN), 64'd1);
      end
      M_RVALID = 1'b1;
      M_RDATA  = rdata;
      M_RRESP  = rresp;
      M_RLAST  = rlast;
      tick();
      M_RVALID = 1'b0;
      M_RLAST  = 1'b1;
      M_RRESP  = 2'b00;
      chk({tag, ".dov"},       64'(DATA_OUT_VALID), 64'd1);
      chk({tag, ".data"},      DATA_OUT,            exp_data);
      chk({tag, ".err"},       64'(ACCESS_ERR),     64'(exp_err));
      chk({tag, ".busy_dov"},  64'(BUSY),           64'd1);
      chk({tag, ".rready_lo"}, 64'(M_RREADY),       64'd0);
      tick();
      chk({tag, ".dov_pulse"}, 64'(DATA_OUT_VALID), 64'd0);
      chk({tag, ".err_clr"},   64'(ACCESS_ERR),     64'd0);
      chk({tag, ".busy_fall"}, 64'(BUSY),           64'd0);
      chk({tag, ".data_hold"}, DATA_OUT,            exp_data);
   endtask

   initial begin
      RST = 1'b1;
      ADDR_IN_VALID = 1'b0;
      ADDR_IN = '0;
      TLB_FLUSH = 1'b0;
      M_ARREADY = 1'b0;
      M_RVALID = 1'b0;
      M_RDATA = '0;
      M_RRESP = 2'b00;
      M_RLAST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      chk_all_zero("reset");
      chk("arid",    64'(M_ARID),    64'd0);
      chk("arlen",   64'(M_ARLEN),   64'd0);
      chk("arsize",  64'(M_ARSIZE),  64'd3);
      chk("arburst", 64'(M_ARBURST), 64'd1);

      do_fetch("basic", 64'h8000_1238, 64'h8000_1238, 0, 0,
               64'h0000_0000_2000_04CF, 2'b00, 1'b1, 64'h0000_0000_2000_04CF, 1'b0, 1'b0);
      do_fetch("bp", 64'h8000_2A47, 64'h8000_2A40, 5, 4,
               64'h0000_0000_3000_1001, 2'b00, 1'b1, 64'h0000_0000_3000_1001, 1'b0, 1'b0);
      do_fetch("slverr", 64'h8000_3000, 64'h8000_3000, 0, 1,
               64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1'b1, 64'd0, 1'b1, 1'b0);
      do_fetch("nolast", 64'h8000_4008, 64'h8000_4008, 1, 0,
               64'h1111_2222_3333_4401, 2'b00, 1'b0, 64'h1111_2222_3333_4401, 1'b1, 1'b0);
      chk("overrun_clear_before", 64'(REQ_OVERRUN), 64'd0);
      do_fetch("ovr", 64'h8000_5010, 64'h8000_5010, 0, 3,
               64'h0000_0000_0000_0055, 2'b00, 1'b1, 64'h0000_0000_0000_0055, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ovr_no_second_ar", 64'(M_ARVALID),   64'd0);
         chk("ovr_sticky",       64'(REQ_OVERRUN), 64'd1);
      end

      // Reset while waiting in R
      ADDR_IN_VALID = 1'b1;
      ADDR_IN       = 64'h8000_6018;
      tick();
      ADDR_IN_VALID = 1'b0;
      M_ARREADY     = 1'b1;
      tick();
      M_ARREADY     = 1'b0;
      chk("midrst_in_r", 64'(M_RREADY), 64'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk_all_zero("midrst");
      tick();
      chk("midrst_no_dov", 64'(DATA_OUT_VALID), 64'd0);
      do_fetch("fresh", 64'h8000_7020, 64'h8000_7020, 0, 0,
               64'h0000_0000_0ABC_DE01, 2'b00, 1'b1, 64'h0000_0000_0ABC_DE01, 1'b0, 1'b0);

`ifdef PTW_LAST_PTE_CACHE_EN
      // Repeat of the last successful address hits the cache: data at t+1, no AR
      ADDR_IN_VALID = 1'b1;
      ADDR_IN       = 64'h8000_7020;
      tick();
      ADDR_IN_VALID = 1'b0;
      chk("hit.dov",     64'(DATA_OUT_VALID), 64'd1);
      chk("hit.data",    DATA_OUT,            64'h0000_0000_0ABC_DE01);
      chk("hit.arvalid", 64'(M_ARVALID),      64'd0);
      chk("hit.err",     64'(ACCESS_ERR),     64'd0);
      tick();
      chk("hit.dov_pulse", 64'(DATA_OUT_VALID), 64'd0);
      chk("hit.busy_fall", 64'(BUSY),           64'd0);
      TLB_FLUSH = 1'b1;
      tick();
      TLB_FLUSH = 1'b0;
      do_fetch("postflush", 64'h8000_7020, 64'h8000_7020, 0, 0,
               64'h0000_0000_0ABC_DE03, 2'b00, 1'b1, 64'h0000_0000_0ABC_DE03, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ptw_pte_fetch_master.md
Name: ptw_pte_fetch_master

Overview:
- AXI4 read master answering page-table-walk PTE fetches from a TLB walker (ITLB/DTLB) over the single-cycle-pulse request/response interface.
- Captures one PTE address pulse, issues a single-beat 64-bit AXI4 read, and returns the PTE with a one-cycle data-valid pulse.
- Sits between the TLB walker and the L2/interconnect AXI port; one outstanding walk at a time.

Parameters:
- ADDR_WIDTH, 64, width of PTE address from walker and of ARADDR.
- DATA_WIDTH, 64, PTE / RDATA width; fixed at 64 (ARSIZE=3).
- ID_WIDTH, 4, AXI ARID/RID width.
- AXI_ID, 0, constant ARID driven on every request.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- ADDR_IN_VALID  input  1  one-cycle pulse: PTE fetch request.
- ADDR_IN  input  ADDR_WIDTH  PTE physical address; sampled only with ADDR_IN_VALID.
- DATA_OUT_VALID  output  1  one-cycle pulse: PTE returned.
- DATA_OUT  output  DATA_WIDTH  PTE; valid only with DATA_OUT_VALID.
- ACCESS_ERR  output  1  pulses with DATA_OUT_VALID when RRESP != OKAY.
- BUSY  output  1  high from request capture until the DATA_OUT_VALID cycle, inclusive.
- REQ_OVERRUN  output  1  sticky: request pulse arrived while BUSY; cleared only by RST.
- TLB_FLUSH  input  1  invalidates the optional PTE cache; otherwise ignored.
- M_ARVALID  output  1  AXI AR valid.
- M_ARREADY  input  1  AXI AR ready.
- M_ARADDR  output  ADDR_WIDTH  AXI read address.
- M_ARID  output  ID_WIDTH  constant AXI_ID.
- M_ARLEN  output  8  constant 0.
- M_ARSIZE  output  3  constant 3'b011.
- M_ARBURST  output  2  constant 2'b01 (INCR).
- M_RVALID  input  1  AXI R valid.
- M_RREADY  output  1  AXI R ready.
- M_RDATA  input  DATA_WIDTH  AXI read data.
- M_RRESP  input  2  AXI read response.
- M_RLAST  input  1  AXI last beat.

Behaviour:
- Reset is synchronous, active-high. All outputs are 0 on reset: DATA_OUT_VALID, DATA_OUT, ACCESS_ERR, BUSY, REQ_OVERRUN, M_ARVALID, M_ARADDR, M_RREADY. State is IDLE.
- States: IDLE, AR, R, RESP.
  - IDLE: on ADDR_IN_VALID, latch ADDR_IN with bits [2:0] forced to 0 into M_ARADDR, set M_ARVALID, go to AR. BUSY rises the same edge.
  - AR: hold M_ARVALID and M_ARADDR stable until M_ARVALID & M_ARREADY. Then drop M_ARVALID, set M_RREADY, go to R.
  - R: hold M_RREADY high. On M_RVALID, go to RESP, drop M_RREADY, and register the beat:
    - RRESP==2'b00: DATA_OUT=M_RDATA, ACCESS_ERR=0.
    - RRESP!=2'b00: DATA_OUT=0 (PTE.V=0, so the walker faults), ACCESS_ERR=1.
    - RLAST is expected high. A beat with RLAST=0 is consumed identically, and ACCESS_ERR is forced to 1.
  - RESP: DATA_OUT_VALID=1 for exactly one cycle, then go to IDLE. DATA_OUT holds its value until the next response. ACCESS_ERR and DATA_OUT_VALID return to 0 after that one cycle.
- Minimum latency: request pulse at cycle t, ARVALID at t+1; with ARREADY at t+1 and RVALID at t+2, DATA_OUT_VALID is at t+3.
- ADDR_IN_VALID while BUSY: request is dropped, REQ_OVERRUN set. ADDR_IN_VALID in the same cycle DATA_OUT_VALID is high also counts as busy, because the walker issues the next address only after consuming data.
- TLB_FLUSH never aborts an in-flight transaction.
- Reset mid-transaction: returns to IDLE immediately, with no DATA_OUT_VALID. The AXI slave must be reset on the same RST.
- An RVALID arriving in IDLE/AR is not accepted, since RREADY is low.

Optional Feature:
- PTW_LAST_PTE_CACHE_EN defined: single-entry cache of the last successful (OKAY) PTE and its address.
  - Hit: request in IDLE whose aligned address matches a valid entry. Skips AXI, goes directly to RESP, returns the cached PTE with DATA_OUT_VALID at t+1.
  - Entry invalidated by RST or TLB_FLUSH. TLB_FLUSH in the same cycle as a request forces a miss.
  - An error response never fills the entry.
- Undefined: every request goes to AXI; TLB_FLUSH is unused.

Test Plan:
- Basic fetch: ADDR_IN=0x8000_1238 pulse at t, ARREADY=1, RDATA=0x0000_0000_2000_04CF, RRESP=0, RVALID at t+2 -> ARADDR=0x8000_1238 at t+1; DATA_OUT_VALID at t+3 with that data; ACCESS_ERR=0.
- Backpressure: ARREADY low 5 cycles, then RVALID delayed 4 cycles -> ARVALID/ARADDR stable throughout; RREADY held; exactly one DATA_OUT_VALID pulse.
- Error: RRESP=2'b10 -> DATA_OUT=0, ACCESS_ERR=1 coincident with DATA_OUT_VALID for one cycle.
- Overrun: second request pulse while in R -> no second AR; REQ_OVERRUN=1 and stays 1 until RST.
- Reset mid-op: RST asserted in state R -> next cycle all outputs 0, no DATA_OUT_VALID; a fresh request then completes normally.
- Cache (PTW_LAST_PTE_CACHE_EN):
  - Two requests to 0x8000_1238 -> second returns at t+1 with no ARVALID.
  - TLB_FLUSH, then the same request -> AXI read issued.
